// File: rtl/demux17_pkg.sv
// demux17_pkg: shared lane count, select width and select helpers for the
// 1-to-17 registered demultiplexer.
package demux17_pkg;

    localparam int NUM_LANES = 17;
    localparam int SEL_W     = 5;

    typedef logic [SEL_W-1:0] lane_sel_t;

    // A select addresses a real lane only when it is below the lane count;
    // the remaining codes of the 5-bit field are dropped and counted.
    function automatic logic sel_legal(lane_sel_t s);
        return (s < lane_sel_t'(NUM_LANES));
    endfunction

endpackage

// File: rtl/demux17_lane.sv
// demux17_lane: one-entry holding buffer for a single output lane.
// A fill on the same cycle as a drain wins, so a busy lane can pass one
// word per cycle straight through.
module demux17_lane #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic [width-1:0] fill_data,
    input  logic             drain,
    output logic             valid,
    output logic [width-1:0] data
);

    logic             valid_q, valid_d;
    logic [width-1:0] data_q,  data_d;

    // Next buffer state: drain empties, fill loads and overrides the drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && drain) begin
            valid_d = 1'b0;
        end
        if (fill) begin
            valid_d = 1'b1;
            data_d  = fill_data;
        end
    end

    // Buffer registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux17.sv
// demux17: registered 1-to-17 demultiplexer with per-lane valid/ready.
// The top decodes the select, forms the combinational in_ready, steers
// accepted words into the lane buffers and counts dropped illegal words.
module demux17
    import demux17_pkg::*;
#(
    parameter int width = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEL_W-1:0]                sel,
    input  logic                            in_valid,
    input  logic [width-1:0]                in_data,
    output logic                            in_ready,
    output logic [NUM_LANES-1:0]            out_valid,
    input  logic [NUM_LANES-1:0]            out_ready,
    output logic [NUM_LANES-1:0][width-1:0] out_data,
    output logic                            err,
    output logic [7:0]                      err_count
);

    logic                 sel_ok;
    logic                 accept;
    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] fill;

    logic       err_q,       err_d;
    logic [7:0] err_count_q, err_count_d;

    // Producer handshake and select decode: a lane can take a word when it
    // is empty or being drained this cycle; illegal selects are always taken.
    always_comb begin
        sel_ok     = sel_legal(sel);
        lane_ready = ~out_valid | out_ready;
        in_ready   = 1'b0;
        if (!rst) begin
            if (sel_ok) begin
                in_ready = lane_ready[sel];
            end else begin
                in_ready = 1'b1;
            end
        end
        accept = in_valid & in_ready;
        fill   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            fill[i] = accept & sel_ok & (sel == lane_sel_t'(i));
        end
    end

    // One buffer per lane; each lane drains on its own consumer's ready.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux17_lane #(
            .width(width)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .fill      (fill[g]),
            .fill_data (in_data),
            .drain     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g])
        );
    end

    // Error pulse and saturating drop counter for accepted illegal words.
    always_comb begin
        err_d       = accept & ~sel_ok;
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Error registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: doc/demux17.md
# demux17

Registered 1-to-17 demultiplexer with per-lane valid/ready handshake: the distributing counterpart to the datapath's 17-input select muxes. One producer stream carries a 5-bit destination select. Each accepted word is steered into a one-entry holding buffer on the selected lane. Each of the 17 consumers drains its own lane independently. Illegal selects (17–31) are consumed, dropped and counted.

## Interface
Parameters:
- `width`, 16, data width of every lane.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  sole clock; all state updates on its rising edge.
  - `rst`  in  1  synchronous, active-high reset.
- Producer side:
  - `sel`  in  5  destination lane for `in_data`; legal 0–16.
  - `in_valid`  in  1  producer offers `sel`/`in_data`.
  - `in_data`  in  width  word to deliver.
  - `in_ready`  out  1  block accepts this cycle; combinational.
- Consumer side:
  - `out_valid`  out  17  bit i = lane i buffer full.
  - `out_ready`  in  17  bit i = consumer i takes lane i this cycle.
  - `out_data`  out  [17][width]  lane buffer contents.
- Error reporting:
  - `err`  out  1  one-cycle pulse, cycle after an illegal select is accepted.
  - `err_count`  out  8  saturating count of dropped words.

## Operation
- accept = `in_valid & in_ready`.
- `in_ready` depends on `sel`:
  - `rst` high: 0.
  - `sel` > 16: 1.
  - Otherwise: `~out_valid[sel] | out_ready[sel]`. A full lane being drained this cycle accepts, giving pass-through throughput.
- Accept with legal `sel`: `out_data[sel]` <= `in_data`, `out_valid[sel]` <= 1 at next edge.
- Drain: `out_valid[i] & out_ready[i]` clears `out_valid[i]` at next edge, unless lane i is refilled the same cycle.
- Simultaneous drain and fill on the same lane: valid stays 1 and data is replaced by the new word.
- Drain on any lane is independent of the producer. All 17 lanes may drain in one cycle.
- Accept with illegal `sel` (17–31): no lane changes, `err` = 1 for exactly one cycle, `err_count` increments and saturates at 255.
- `out_data[i]` holds its last value while `out_valid[i]` = 0, and is stable while `out_valid[i] & ~out_ready[i]`.
- `out_ready[i]` when `out_valid[i]` = 0: ignored.
- `sel` and `in_data` are ignored when `in_valid` = 0.

## Timing
- Reset values: `out_valid` = 0, every `out_data[i]` = 0, `err` = 0, `err_count` = 0, `in_ready` = 0 while `rst` is high.
- Reset mid-operation: buffered words are discarded and no accept occurs in a reset cycle.
- Latency: accept at edge N means `out_valid[sel]` = 1 in cycle N+1.
- Throughput: one word per cycle, sustained to one lane if its consumer holds ready, or spread across lanes.
- Lane back-pressure: a full, undrained lane stalls only words addressed to it. Words addressed to other lanes proceed.
- `err` is registered and never asserted for two consecutive cycles unless illegal words are accepted on consecutive cycles.
- Combinational paths: `out_ready` -> `in_ready` and `sel` -> `in_ready`. Everything else is registered.

## Structure
- Package `demux17_pkg`:
  - constants `NUM_LANES` = 17 and `SEL_W` = 5;
  - typedef `lane_sel_t` (logic [SEL_W-1:0]);
  - function `sel_legal(lane_sel_t)`.
- Sub-module `demux17_lane`: one-entry buffer with inputs `fill`, `fill_data`, `drain`, outputs `valid`, `data`, and `clk`/`rst`. Instantiated 17× via generate.
- Top level holds the select decode, `in_ready` logic and the error counter.

## Test plan
- Reset then single word: release `rst`, `sel`=5, `in_data`=16'hBEEF, `in_valid`=1, `out_ready`=0 -> next cycle `out_valid`=17'h00020, `out_data[5]`=BEEF. A second word to lane 5 sees `in_ready`=0.
- Pass-through: lane 3 full with 16'h1111, `out_ready[3]`=1, new word `sel`=3, 16'h2222 -> `in_ready`=1. Next cycle `out_valid[3]`=1, `out_data[3]`=2222.
- Per-lane stall isolation: lane 0 full and not ready. Words to lanes 1, 16, 0 on consecutive cycles -> lanes 1 and 16 fill; third word stalls (`in_ready`=0) until `out_ready[0]` pulses.
- Illegal select: `sel`=17 then `sel`=31, each with `in_valid`=1 -> `in_ready`=1, `out_valid` unchanged, `err` high for two cycles, `err_count`=2. After 300 illegal words `err_count`=255.
- Parallel drain: fill all 17 lanes with values 0–16, assert `out_ready`=17'h1FFFF one cycle -> next cycle `out_valid`=0, data held.
- Reset mid-stream: lanes 2 and 9 full, assert `rst` one cycle with `in_valid`=1 -> `in_ready`=0, and next cycle `out_valid`=0, `out_data` all 0, `err_count`=0.
